// File: rtl/hyperbus_tx_if.sv
// hyperbus_tx_if: command, write-data and DDR-cell output bundle for hyperbus_tx_serializer.
// slave = serializer side, master = command/data source and PHY cell side.
interface hyperbus_tx_if #(
    parameter int LAT_W = 4,
    parameter int LEN_W = 8
) ();
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [47:0]      cmd_ca_i;
    logic             cmd_write_i;
    logic [LAT_W-1:0] cmd_lat_i;
    logic [LEN_W-1:0] cmd_len_i;
    logic             wdata_valid_i;
    logic             wdata_ready_o;
    logic [15:0]      wdata_i;
    logic [1:0]       wstrb_i;
    logic [7:0]       dq_d0_o;
    logic [7:0]       dq_d1_o;
    logic             dq_oe_o;
    logic             rwds_d0_o;
    logic             rwds_d1_o;
    logic             rwds_oe_o;
    logic             clk_en_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  cmd_valid_i, cmd_ca_i, cmd_write_i, cmd_lat_i, cmd_len_i,
        input  wdata_valid_i, wdata_i, wstrb_i,
        output cmd_ready_o, wdata_ready_o,
        output dq_d0_o, dq_d1_o, dq_oe_o, rwds_d0_o, rwds_d1_o, rwds_oe_o,
        output clk_en_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_ca_i, cmd_write_i, cmd_lat_i, cmd_len_i,
        output wdata_valid_i, wdata_i, wstrb_i,
        input  cmd_ready_o, wdata_ready_o,
        input  dq_d0_o, dq_d1_o, dq_oe_o, rwds_d0_o, rwds_d1_o, rwds_oe_o,
        input  clk_en_o, busy_o, done_o
    );
endinterface

// File: rtl/hyperbus_tx_serializer.sv
// hyperbus_tx_serializer: HyperBus TX sequencer (CA, latency, write burst) with registered DDR-cell outputs.
// Define HYPERBUS_TX_MASK_EN to drive RWDS byte masks from wstrb_i during write data.
module hyperbus_tx_serializer #(
    parameter int LAT_W = 4,
    parameter int LEN_W = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    hyperbus_tx_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CA0,
        S_CA1,
        S_CA2,
        S_LAT,
        S_DATA
    } state_t;

    state_t           r_state;
    logic [47:0]      r_ca;
    logic             r_write;
    logic [LAT_W-1:0] r_lat;
    logic [LEN_W-1:0] r_cnt;

    logic [7:0]       r_dq_d0;
    logic [7:0]       r_dq_d1;
    logic             r_dq_oe;
    logic             r_rwds_d0;
    logic             r_rwds_d1;
    logic             r_rwds_oe;
    logic             r_clk_en;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_done;

    logic [15:0]      w_ca_word;
    logic [1:0]       w_rwds;

`ifdef HYPERBUS_TX_MASK_EN
    // RWDS high marks a masked byte: [1] -> d0 (byte [15:8]), [0] -> d1 (byte [7:0])
    assign w_rwds = ~bus.wstrb_i;
`else
    logic w_unused_strb;
    assign w_unused_strb = ^bus.wstrb_i;
    assign w_rwds        = '0;
`endif

    always_comb begin
        w_ca_word = r_ca[15:0];
        case (r_state)
            S_CA0:   w_ca_word = r_ca[47:32];
            S_CA1:   w_ca_word = r_ca[31:16];
            default: w_ca_word = r_ca[15:0];
        endcase
    end

    // Outputs are registered from the current state, so they lag the state by one cycle;
    // cmd_ready/busy are registered from the next state and therefore track it exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ca        <= '0;
            r_write     <= 1'b0;
            r_lat       <= '0;
            r_cnt       <= '0;
            r_dq_d0     <= '0;
            r_dq_d1     <= '0;
            r_dq_oe     <= 1'b0;
            r_rwds_d0   <= 1'b0;
            r_rwds_d1   <= 1'b0;
            r_rwds_oe   <= 1'b0;
            r_clk_en    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_dq_d0   <= '0;
                    r_dq_d1   <= '0;
                    r_dq_oe   <= 1'b0;
                    r_rwds_d0 <= 1'b0;
                    r_rwds_d1 <= 1'b0;
                    r_rwds_oe <= 1'b0;
                    r_clk_en  <= 1'b0;
                    if (bus.cmd_valid_i) begin
                        r_ca        <= bus.cmd_ca_i;
                        r_write     <= bus.cmd_write_i;
                        r_lat       <= bus.cmd_lat_i;
                        r_cnt       <= bus.cmd_len_i;
                        r_state     <= S_CA0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_CA0, S_CA1, S_CA2: begin
                    {r_dq_d0, r_dq_d1} <= w_ca_word;
                    r_dq_oe   <= 1'b1;
                    r_rwds_d0 <= 1'b0;
                    r_rwds_d1 <= 1'b0;
                    r_rwds_oe <= 1'b0;
                    r_clk_en  <= 1'b1;
                    if (r_state == S_CA0) begin
                        r_state <= S_CA1;
                    end else if (r_state == S_CA1) begin
                        r_state <= S_CA2;
                    end else if (!r_write) begin
                        r_state     <= S_IDLE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (r_lat == '0) begin
                        r_state <= S_DATA;
                    end else begin
                        r_state <= S_LAT;
                    end
                end
                S_LAT: begin
                    r_dq_d0   <= '0;
                    r_dq_d1   <= '0;
                    r_dq_oe   <= 1'b0;
                    r_rwds_d0 <= 1'b0;
                    r_rwds_d1 <= 1'b0;
                    r_rwds_oe <= 1'b0;
                    r_clk_en  <= 1'b1;
                    r_lat     <= r_lat - LAT_W'(1);
                    if (r_lat == LAT_W'(1)) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.wdata_valid_i) begin
                        r_dq_d0   <= bus.wdata_i[15:8];
                        r_dq_d1   <= bus.wdata_i[7:0];
                        r_dq_oe   <= 1'b1;
                        r_rwds_d0 <= w_rwds[1];
                        r_rwds_d1 <= w_rwds[0];
                        r_rwds_oe <= 1'b1;
                        r_clk_en  <= 1'b1;
                        if (r_cnt == '0) begin
                            r_state     <= S_IDLE;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - LEN_W'(1);
                        end
                    end else begin
                        // underrun: stop CK, leave DQ/RWDS and their enables where they were
                        r_clk_en <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o   = r_cmd_ready;
    assign bus.wdata_ready_o = (r_state == S_DATA);
    assign bus.dq_d0_o       = r_dq_d0;
    assign bus.dq_d1_o       = r_dq_d1;
    assign bus.dq_oe_o       = r_dq_oe;
    assign bus.rwds_d0_o     = r_rwds_d0;
    assign bus.rwds_d1_o     = r_rwds_d1;
    assign bus.rwds_oe_o     = r_rwds_oe;
    assign bus.clk_en_o      = r_clk_en;
    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
endmodule

// File: tb/tb_hyperbus_tx_serializer.sv
// tb_hyperbus_tx_serializer: self-checking bench; expected per-cycle outputs come from a
// timeline model built from command fields, word list and underrun gaps.
module tb_hyperbus_tx_serializer;
    localparam int LAT_W = 4;
    localparam int LEN_W = 8;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       oe;
        logic       r0;
        logic       r1;
        logic       roe;
        logic       cke;
        logic       done;
        logic       rdy;
        logic       busy;
        logic       wrdy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] p_words[$];
    logic [1:0]  p_strb[$];
    int          p_gap[$];
    int          p_hs[$];
    int          exp_d;
    int          exp_e;
    int          exp_last;
    obs_t        exp_q[$];
    obs_t        obs_q[$];

    hyperbus_tx_if #(.LAT_W(LAT_W), .LEN_W(LEN_W)) bus ();

    hyperbus_tx_serializer #(.LAT_W(LAT_W), .LEN_W(LEN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.d0   = bus.dq_d0_o;
        o.d1   = bus.dq_d1_o;
        o.oe   = bus.dq_oe_o;
        o.r0   = bus.rwds_d0_o;
        o.r1   = bus.rwds_d1_o;
        o.roe  = bus.rwds_oe_o;
        o.cke  = bus.clk_en_o;
        o.done = bus.done_o;
        o.rdy  = bus.cmd_ready_o;
        o.busy = bus.busy_o;
        o.wrdy = bus.wdata_ready_o;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    function automatic void clear_plan();
        p_words.delete();
        p_strb.delete();
        p_gap.delete();
    endfunction

    // Handshake at cycle 0; CA states 1..3; LAT 4..3+lat; DATA from 4+lat, word i accepted
    // after its gap; outputs at cycle j reflect what the sequence dictated at cycle j-1.
    task automatic build_exp(input logic [47:0] ca, input logic wr, input int lat);
        obs_t        o;
        int          t;
        int          wi;
        logic [15:0] hw;
        exp_q.delete();
        p_hs.delete();
        exp_d    = 4 + lat;
        exp_last = -1;
        if (wr) begin
            t = exp_d;
            foreach (p_words[i]) begin
                t += p_gap[i];
                p_hs.push_back(t);
                t++;
            end
            exp_last = p_hs[p_hs.size() - 1];
            exp_e    = exp_last + 1;
        end else begin
            exp_e = 4;
        end
        o = '0;
        for (int j = 1; j <= exp_e + 1; j++) begin
            o.done = (j == exp_e);
            o.rdy  = (j >= exp_e);
            o.busy = (j < exp_e);
            o.wrdy = wr && (j >= exp_d) && (j <= exp_last);
            if (j == 1 || j == exp_e + 1) begin
                {o.d0, o.d1, o.oe, o.r0, o.r1, o.roe, o.cke} = '0;
            end else if (j <= 4) begin
                hw = 16'(ca >> (16 * (4 - j)));
                {o.d0, o.d1} = hw;
                {o.oe, o.r0, o.r1, o.roe, o.cke} = 5'b10001;
            end else if (j <= exp_d) begin
                {o.d0, o.d1, o.oe, o.r0, o.r1, o.roe} = '0;
                o.cke = 1'b1;
            end else begin
                wi = -1;
                foreach (p_hs[i]) if (p_hs[i] == j - 1) wi = i;
                if (wi >= 0) begin
                    {o.d0, o.d1} = p_words[wi];
                    o.oe  = 1'b1;
                    o.roe = 1'b1;
                    o.cke = 1'b1;
`ifdef HYPERBUS_TX_MASK_EN
                    o.r0 = ~p_strb[wi][1];
                    o.r1 = ~p_strb[wi][0];
`else
                    o.r0 = 1'b0;
                    o.r1 = 1'b0;
`endif
                end else begin
                    o.cke = 1'b0;
                end
            end
            exp_q.push_back(o);
        end
    endtask

    task automatic drive_wdata(input int j);
        int wi = -1;
        foreach (p_hs[i]) if (p_hs[i] == j) wi = i;
        if (wi >= 0) begin
            bus.wdata_valid_i = 1'b1;
            bus.wdata_i       = p_words[wi];
            bus.wstrb_i       = p_strb[wi];
        end else begin
            // junk offered outside DATA must not be consumed; inside DATA this is an underrun
            bus.wdata_valid_i = !(j >= exp_d && j <= exp_last);
            bus.wdata_i       = 16'($urandom());
            bus.wstrb_i       = 2'($urandom());
        end
    endtask

    task automatic run_txn(input logic [47:0] ca, input logic wr, input int lat);
        obs_q.delete();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_ca_i    = ca;
        bus.cmd_write_i = wr;
        bus.cmd_lat_i   = LAT_W'(lat);
        bus.cmd_len_i   = LEN_W'(p_words.size() - 1);
        drive_wdata(0);
        for (int j = 1; j <= exp_e + 1; j++) begin
            @(posedge clk);
            #1;
            bus.cmd_valid_i = 1'b0;
            bus.cmd_ca_i    = 48'({$urandom(), $urandom()});
            bus.cmd_write_i = ~wr;
            bus.cmd_lat_i   = LAT_W'($urandom());
            bus.cmd_len_i   = LEN_W'($urandom());
            obs_q.push_back(sample());
            drive_wdata(j);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sample() !== idle_obs()) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", sample(), idle_obs());
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        @(posedge clk);
        #1;
        clear_plan();
        build_exp(48'hA0B1_C2D3_E4F5, 1'b0, 2);
        run_txn(48'hA0B1_C2D3_E4F5, 1'b0, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL read cyc=%0d got=%h exp=%h", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_write_lat();
        @(posedge clk);
        #1;
        clear_plan();
        p_words = '{16'h1234, 16'h5678};
        p_strb  = '{2'b11, 2'b11};
        p_gap   = '{0, 0};
        build_exp(48'h1122_3344_5566, 1'b1, 3);
        run_txn(48'h1122_3344_5566, 1'b1, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL write_lat cyc=%0d got=%h exp=%h", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_underrun();
        @(posedge clk);
        #1;
        clear_plan();
        p_words = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        p_strb  = '{2'b11, 2'b01, 2'b11};
        p_gap   = '{0, 2, 0};
        build_exp(48'hFEDC_BA98_7654, 1'b1, 1);
        run_txn(48'hFEDC_BA98_7654, 1'b1, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL underrun cyc=%0d got=%h exp=%h", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_mask();
        logic [1:0] want;
`ifdef HYPERBUS_TX_MASK_EN
        want = 2'b01;
`else
        want = 2'b00;
`endif
        @(posedge clk);
        #1;
        clear_plan();
        p_words = '{16'hA55A};
        p_strb  = '{2'b10};
        p_gap   = '{0};
        build_exp(48'h0102_0304_0506, 1'b1, 0);
        run_txn(48'h0102_0304_0506, 1'b1, 0);
        checks++;
        if ({obs_q[4].r0, obs_q[4].r1} !== want) begin
            errors++;
            $display("FAIL mask_rwds got=%b exp=%b", {obs_q[4].r0, obs_q[4].r1}, want);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL mask cyc=%0d got=%h exp=%h", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_in_lat();
        @(posedge clk);
        #1;
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_ca_i      = 48'h1357_9BDF_2468;
        bus.cmd_write_i   = 1'b1;
        bus.cmd_lat_i     = LAT_W'(6);
        bus.cmd_len_i     = '0;
        bus.wdata_valid_i = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            #1;
            bus.cmd_valid_i = 1'b0;
            if (j == 5) rst = 1'b1;
            if (j >= 6) begin
                checks++;
                if (sample() !== idle_obs()) begin
                    errors++;
                    $display("FAIL reset_in_lat cyc=%0d got=%h exp=%h", j, sample(), idle_obs());
                end
                rst = 1'b0;
            end
        end
        bus.wdata_valid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        @(posedge clk);
        #1;
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_ca_i      = 48'h0A0B_0C0D_0E0F;
        bus.cmd_write_i   = 1'b1;
        bus.cmd_lat_i     = '0;
        bus.cmd_len_i     = '0;
        bus.wdata_valid_i = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            o = sample();
            bus.cmd_ca_i      = 48'h9876_5432_10FE;
            bus.cmd_write_i   = 1'b0;
            bus.cmd_lat_i     = LAT_W'(5);
            bus.cmd_len_i     = LEN_W'(3);
            bus.wdata_valid_i = (j == 4);
            bus.wdata_i       = 16'hC3D4;
            bus.wstrb_i       = 2'b11;
            if (j == 6) bus.cmd_valid_i = 1'b0;
            if (j == 4) begin
                checks++;
                if (o.wrdy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_wrdy got=%b exp=1", o.wrdy);
                end
            end
            if (j == 5) begin
                checks++;
                if ({o.d0, o.d1, o.oe, o.done, o.rdy} !== {16'hC3D4, 3'b111}) begin
                    errors++;
                    $display("FAIL b2b_done got=%h exp=%h", {o.d0, o.d1, o.oe, o.done, o.rdy}, {16'hC3D4, 3'b111});
                end
            end
            if (j == 6) begin
                checks++;
                if ({o.busy, o.rdy, o.done} !== 3'b100) begin
                    errors++;
                    $display("FAIL b2b_accept got=%b exp=100", {o.busy, o.rdy, o.done});
                end
            end
            if (j == 7) begin
                checks++;
                if ({o.d0, o.d1, o.oe} !== {16'h9876, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_ca got=%h exp=%h", {o.d0, o.d1, o.oe}, {16'h9876, 1'b1});
                end
            end
            if (j == 9 || j == 10) begin
                checks++;
                if ({o.done, o.rdy} !== {(j == 9), 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_end cyc=%0d got=%b exp=%b", j, {o.done, o.rdy}, {(j == 9), 1'b1});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [47:0] ca;
        logic        wr;
        int          lat;
        int          len;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            clear_plan();
            ca  = 48'({$urandom(), $urandom()});
            wr  = (n == 7) || ($urandom_range(0, 3) != 0);
            lat = (n == 7) ? 0 : int'($urandom_range(0, 15));
            len = (n == 7) ? 255 : int'($urandom_range(0, 7));
            if (wr) begin
                for (int i = 0; i <= len; i++) begin
                    p_words.push_back(16'($urandom()));
                    p_strb.push_back(2'($urandom()));
                    p_gap.push_back((n == 7) ? 0 : int'($urandom_range(0, 2)));
                end
            end
            build_exp(ca, wr, lat);
            run_txn(ca, wr, lat);
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL random%0d cyc=%0d got=%h exp=%h", n, k + 1, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_ca_i      = '0;
        bus.cmd_write_i   = 1'b0;
        bus.cmd_lat_i     = '0;
        bus.cmd_len_i     = '0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = '0;
        bus.wstrb_i       = '0;
        test_reset();
        test_read();
        test_write_lat();
        test_underrun();
        test_mask();
        test_reset_in_lat();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
